bcd_counter_n: RTL and testbench
================================

// Module: bcd_counter_n
// PURPOSE
//  Synchronous N-digit BCD up/down counter with parallel load, clear and wrap/overflow flags.
//  All digits share clk_0; carries between digits are combinational enables, not derived clocks.
//  Feeds the 7-segment display/frequency-measurement path; one instance per measured channel.
// PARAMETERS
//  NDIG     4   number of BCD decades (1..8); count width = 4*NDIG
//  DIR_UP   1   direction used when dir_sel_en=0 (1 = up, 0 = down)
// PORTS
//  clk_0       in   1        clock, all state updates on posedge
//  reset       in   1        asynchronous, active-low; clears all state
//  limp        in   1        synchronous clear, highest priority after reset
//  load        in   1        synchronous parallel load of load_val
//  load_val    in   4*NDIG   BCD load value, digit 0 in [3:0]
//  hab         in   1        count enable, one step per cycle while high
//  dir_sel_en  in   1        1 = use dir, 0 = use DIR_UP
//  dir         in   1        1 = count up, 0 = count down
//  count       out  4*NDIG   BCD count, digit 0 in [3:0]
//  carry       out  1        registered 1-cycle pulse on wrap (up 9..9->0..0, down 0..0->9..9)
//  ovf         out  1        sticky wrap/overflow flag
// BEHAVIOUR
//  - reset low (async): count=0, carry=0, ovf=0; held while low, release sync to clk_0.
//  - Priority per posedge: limp > load > hab > hold.
//  - limp: count=0, carry=0, ovf=0 next cycle.
//  - load: each digit takes load_val digit; digits >9 are clamped to 9; carry=0; ovf unchanged.
//  - hab & up: digit k increments iff all lower digits ==9; digit at 9 goes to 0.
//  - hab & down: digit k decrements iff all lower digits ==0; digit at 0 goes to 9.
//  - carry: high for exactly the cycle after a wrapping step; 0 in all other cycles.
//  - ovf: set with carry; cleared only by limp or reset.
//  - Latency: count reflects a step/load/clear one cycle after the sampling edge.
//  - dir change mid-count takes effect on the same edge it is sampled; no extra cycle.
//  - load and hab together: load wins, no step that cycle.
//  - Digits never hold 10..15 after reset, for any input sequence.
// CONFIGURATION
//  - Macro BCD_COUNTER_SAT_EN:
//    - defined: saturating mode. Up at 9..9 and down at 0..0 hold count.
//      carry stays 0. ovf is set on the attempted step.
//    - undefined: wrap-around mode as described in BEHAVIOUR.
// STRUCTURE
//  - Package bcd_pkg:
//    - typedef logic [3:0] bcd_digit_t
//    - localparam bcd_digit_t BCD_MAX = 4'd9, BCD_MIN = 4'd0
//    - function bcd_clamp(bcd_digit_t) returning min(d,9)
//  - Sub-module bcd_digit (one decade):
//    - inputs: clk_0, reset, clr, ld, ld_val, en, up
//    - outputs: q, tc_up (q==9), tc_dn (q==0)
//    - instantiated NDIG times by a generate loop
//    - enable chain is the AND of lower-digit tc_up/tc_dn
//  - carry/ovf registers live in the top level.
// TESTING (NDIG=4)
//  - reset low mid-count at 0347 -> count=0000, carry=0, ovf=0 immediately, no clk_0 edge required.
//  - load 0x9998, hab=1 up 3 cycles -> 9999, 0000 with carry=1 for 1 cycle, 0001; ovf=1 stays.
//  - load 0x0000, hab=1 down 1 cycle -> 9999, carry pulse, ovf=1; limp next -> 0000, ovf=0.
//  - load_val 0xF3A9 -> count=9399 (nibbles >9 clamped).
//  - load=1 and hab=1 at 0x0500 -> 0500, no step; dir toggled every cycle from 0500 -> 0501, 0500, 0501.
//  - BCD_COUNTER_SAT_EN defined, 9999 up, hab=1 -> holds 9999, carry=0, ovf=1.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the bcd_counter_n slice.
// Contents:
//   bcd_digit_t        one BCD decade (4 bits)
//   BCD_MAX / BCD_MIN  terminal digit values (9 / 0)
//   bcd_clamp()        limits a nibble to a legal BCD digit, min(d, 9)
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the bcd_counter_n counter.
// Ports:
//   clk_0   in   clock, state updates on posedge
//   reset   in   asynchronous, active-low clear
//   clr     in   synchronous clear (highest synchronous priority)
//   ld      in   synchronous load of ld_val (clamped to 9)
//   ld_val  in   digit load value
//   en      in   step enable for this decade (already gated by lower decades)
//   up      in   1 = increment, 0 = decrement
//   q       out  current digit value, always 0..9
//   tc_up   out  q == 9 (this decade would wrap on an up step)
//   tc_dn   out  q == 0 (this decade would wrap on a down step)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk_0,
  input  logic       reset,
  input  logic       clr,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  logic       en,
  input  logic       up,
  output bcd_digit_t q,
  output logic       tc_up,
  output logic       tc_dn
);

  bcd_digit_t q_next;

  always_comb begin
    q_next = q;
    if (up) begin
      // Anything at or above 9 rolls to 0, so an out-of-range value can never persist.
      q_next = (q >= BCD_MAX) ? BCD_MIN : q + 4'd1;
    end else begin
      q_next = (q == BCD_MIN) ? BCD_MAX : bcd_clamp(q - 4'd1);
    end
  end

  always_ff @(posedge clk_0 or negedge reset) begin
    if (!reset) begin
      q <= BCD_MIN;
    end else if (clr) begin
      q <= BCD_MIN;
    end else if (ld) begin
      q <= bcd_clamp(ld_val);
    end else if (en) begin
      q <= q_next;
    end
  end

  assign tc_up = (q == BCD_MAX);
  assign tc_dn = (q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit synchronous BCD up/down counter with parallel load, clear,
// registered wrap pulse and sticky overflow flag.
// Optional feature macro: BCD_COUNTER_SAT_EN
//   defined   -> saturating: up at 9..9 / down at 0..0 holds, carry stays 0,
//                ovf is set on the attempted step
//   undefined -> wrap-around (default)
// Parameters:
//   NDIG    number of decades (1..8), count width 4*NDIG
//   DIR_UP  direction when dir_sel_en = 0 (1 = up, 0 = down)
// Ports:
//   clk_0       in   clock
//   reset       in   asynchronous, active-low, clears count/carry/ovf
//   limp        in   synchronous clear (beats load and hab)
//   load        in   synchronous parallel load of load_val (beats hab)
//   load_val    in   BCD load value, digit 0 in [3:0]; nibbles >9 clamp to 9
//   hab         in   count enable, one step per cycle
//   dir_sel_en  in   1 = use dir, 0 = use DIR_UP
//   dir         in   1 = up, 0 = down
//   count       out  BCD count, digit 0 in [3:0]
//   carry       out  one-cycle pulse after a wrapping step
//   ovf         out  sticky wrap/overflow flag (cleared by limp or reset)
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter bit DIR_UP = 1'b1
) (
  input  logic              clk_0,
  input  logic              reset,
  input  logic              limp,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              hab,
  input  logic              dir_sel_en,
  input  logic              dir,
  output logic [4*NDIG-1:0] count,
  output logic              carry,
  output logic              ovf
);

  logic            up;
  logic [NDIG-1:0] tc_up;
  logic [NDIG-1:0] tc_dn;
  logic [NDIG-1:0] term;
  logic [NDIG-1:0] en;
  logic            all_term;
  logic            wrap;
  logic            step_go;

  assign up = dir_sel_en ? dir : DIR_UP;

  // A decade is "terminal" when the next step in the current direction wraps it.
  assign term     = up ? tc_up : tc_dn;
  assign all_term = &term;
  // Attempted step out of 9..9 (up) or 0..0 (down); only meaningful when hab wins priority.
  assign wrap     = hab & all_term;

`ifdef BCD_COUNTER_SAT_EN
  assign step_go = hab & ~all_term;
`else
  assign step_go = hab;
`endif

  // Ripple enable: decade k steps only when every lower decade is terminal.
  always_comb begin
    en[0] = step_go;
    for (int k = 1; k < NDIG; k++) begin
      en[k] = en[k-1] & term[k-1];
    end
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_digit
    bcd_digit u_digit (
      .clk_0  (clk_0),
      .reset  (reset),
      .clr    (limp),
      .ld     (load),
      .ld_val (load_val[4*k +: 4]),
      .en     (en[k]),
      .up     (up),
      .q      (count[4*k +: 4]),
      .tc_up  (tc_up[k]),
      .tc_dn  (tc_dn[k])
    );
  end

  always_ff @(posedge clk_0 or negedge reset) begin
    if (!reset) begin
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (limp) begin
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      carry <= 1'b0;
    end else if (hab) begin
`ifdef BCD_COUNTER_SAT_EN
      carry <= 1'b0;
`else
      carry <= wrap;
`endif
      if (wrap) ovf <= 1'b1;
    end else begin
      carry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
module tb_bcd_counter_n;

  localparam int NDIG = 4;
  localparam int CW   = 4*NDIG;

  logic          clk_0 = 1'b0;
  logic          reset;
  logic          limp;
  logic          load;
  logic [CW-1:0] load_val;
  logic          hab;
  logic          dir_sel_en;
  logic          dir;
  logic [CW-1:0] count;
  logic          carry;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_counter_n #(.NDIG(NDIG), .DIR_UP(1'b1)) dut (
    .clk_0      (clk_0),
    .reset      (reset),
    .limp       (limp),
    .load       (load),
    .load_val   (load_val),
    .hab        (hab),
    .dir_sel_en (dir_sel_en),
    .dir        (dir),
    .count      (count),
    .carry      (carry),
    .ovf        (ovf)
  );

  always #5 clk_0 = ~clk_0;

  typedef struct {
    logic          limp;
    logic          load;
    logic [CW-1:0] load_val;
    logic          hab;
    logic          dir_sel_en;
    logic          dir;
    logic [CW-1:0] exp_count;
    logic          exp_carry;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [CW-1:0] c, input logic cy, input logic ov);
    n_checks += 3;
    if (count !== c) begin
      n_fail++;
      $display("FAIL %s count: got %h expected %h", name, count, c);
    end
    if (carry !== cy) begin
      n_fail++;
      $display("FAIL %s carry: got %b expected %b", name, carry, cy);
    end
    if (ovf !== ov) begin
      n_fail++;
      $display("FAIL %s ovf: got %b expected %b", name, ovf, ov);
    end
  endtask

  task automatic add(input logic l, input logic ld, input logic [CW-1:0] lv, input logic h,
                     input logic ds, input logic d, input logic [CW-1:0] ec,
                     input logic ecy, input logic eov);
    vec_t v;
    v.limp = l; v.load = ld; v.load_val = lv; v.hab = h; v.dir_sel_en = ds; v.dir = d;
    v.exp_count = ec; v.exp_carry = ecy; v.exp_ovf = eov;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic l, input logic ld, input logic [CW-1:0] lv,
                       input logic h, input logic ds, input logic d);
    limp = l; load = ld; load_val = lv; hab = h; dir_sel_en = ds; dir = d;
  endtask

  initial begin
    //          limp load val      hab dsel dir  count    cy ov
    add(1'b0, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0, 16'h9998, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0);
`ifdef BCD_COUNTER_SAT_EN
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b1);
`else
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1);
`endif
    // load keeps ovf
    add(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1);
    // limp beats load and hab
    add(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef BCD_COUNTER_SAT_EN
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
`else
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b1);
`endif
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    // clamped load
    add(1'b0, 1'b1, 16'hF3A9, 1'b0, 1'b0, 1'b0, 16'h9399, 1'b0, 1'b0);
    // load with hab: no step, then dir toggling
    add(1'b0, 1'b1, 16'h0500, 1'b1, 1'b0, 1'b0, 16'h0500, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0501, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0500, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0501, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0501, 1'b0, 1'b0);
    // mid-chain carries/borrows
    add(1'b0, 1'b1, 16'h0199, 1'b0, 1'b0, 1'b0, 16'h0199, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0199, 1'b0, 1'b0);
    add(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0999, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b0);

    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #12;
    check("reset_state", 16'h0000, 1'b0, 1'b0);
    @(negedge clk_0);
    reset = 1'b1;
    @(negedge clk_0);
    check("after_reset", 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].limp, vecs[i].load, vecs[i].load_val, vecs[i].hab,
            vecs[i].dir_sel_en, vecs[i].dir);
      @(posedge clk_0);
      @(negedge clk_0);
      check($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_carry, vecs[i].exp_ovf);
    end

    // Set ovf, then reach 0347 and pull reset asynchronously mid-cycle.
    drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0);
    @(posedge clk_0); @(negedge clk_0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(posedge clk_0); @(negedge clk_0);
`ifdef BCD_COUNTER_SAT_EN
    check("pre_wrap", 16'h9999, 1'b0, 1'b1);
`else
    check("pre_wrap", 16'h0000, 1'b1, 1'b1);
`endif
    drive(1'b0, 1'b1, 16'h0347, 1'b0, 1'b0, 1'b0);
    @(posedge clk_0); @(negedge clk_0);
    check("at_0347", 16'h0347, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 16'h0000, 1'b0, 1'b0);
    @(posedge clk_0); @(negedge clk_0);
    check("reset_held", 16'h0000, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk_0); @(negedge clk_0);
    check("post_reset_step", 16'h0001, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
